csr_access_unit: RTL and testbench

//  Executes Zicsr instructions: CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI and CSRRCI.

---
 rtl/csr_access_unit_pkg.sv | 23 ++
 rtl/csr_op_alu.sv | 40 ++++
 rtl/csr_access_unit.sv | 118 +++++++++++
 tb/tb_csr_access_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_access_unit_pkg.sv
// Shared types and constants for the Zicsr access unit: funct3 codes,
// FSM state encoding and a small operation-class helper.
package csr_access_unit_pkg;

   localparam logic [2:0] CSR_RW  = 3'b001;
   localparam logic [2:0] CSR_RS  = 3'b010;
   localparam logic [2:0] CSR_RC  = 3'b011;
   localparam logic [2:0] CSR_RWI = 3'b101;
   localparam logic [2:0] CSR_RSI = 3'b110;
   localparam logic [2:0] CSR_RCI = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2
   } state_t;

   // funct3 000/100 sit in the SYSTEM opcode space but are not CSR ops
   function automatic logic is_csr_op(input logic [2:0] funct3);
      return funct3[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/csr_op_alu.sv
// Combinational read-modify-write datapath: selects the register or zimm
// operand and forms the new CSR value plus its write enable.
module csr_op_alu
   import csr_access_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] old_val,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [4:0]      rs1_idx,
   output logic [XLEN-1:0] new_val,
   output logic            write_en
);

   logic [XLEN-1:0] src;

   always_comb begin
      src      = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_idx} : rs1_data;
      new_val  = '0;
      write_en = 1'b0;
      // set/clear with rs1=x0 (or zimm=0) is a pure read and must not write
      case (funct3)
         CSR_RW, CSR_RWI: begin
            new_val  = src;
            write_en = 1'b1;
         end
         CSR_RS, CSR_RSI: begin
            new_val  = old_val | src;
            write_en = |rs1_idx;
         end
         CSR_RC, CSR_RCI: begin
            new_val  = old_val & ~src;
            write_en = |rs1_idx;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/csr_access_unit.sv
// Zicsr execution unit: IDLE -> READ -> WRITE sequence against a CSR file
// with a combinational read port. Optional checks under CSR_ACCESS_CHECK_EN.
module csr_access_unit
   import csr_access_unit_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int CSR_AW = 12
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [2:0]        i_funct3,
   input  logic [4:0]        i_rs1_idx,
   input  logic [XLEN-1:0]   i_rs1_data,
   input  logic [CSR_AW-1:0] i_csr_addr,
   input  logic [4:0]        i_rd_addr,
   output logic [CSR_AW-1:0] o_csr_addr,
   input  logic [XLEN-1:0]   i_csr_rdata,
   output logic              o_csr_we,
   output logic [XLEN-1:0]   o_csr_wdata,
   output logic              o_wb_valid,
   output logic [4:0]        o_wb_rd,
   output logic [XLEN-1:0]   o_wb_data,
   output logic              o_illegal
);

   state_t            state, state_nxt;
   logic [2:0]        funct3;
   logic [4:0]        rs1_idx, rd;
   logic [XLEN-1:0]   rs1_data, old_val, new_val, alu_new;
   logic [CSR_AW-1:0] addr;
   logic              write_en, alu_we, accept, illegal;

   assign accept = (state == S_IDLE) && i_valid;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         funct3   <= '0;
         rs1_idx  <= '0;
         rs1_data <= '0;
         addr     <= '0;
         rd       <= '0;
         old_val  <= '0;
         new_val  <= '0;
         write_en <= 1'b0;
      end else begin
         if (accept) begin
            funct3   <= i_funct3;
            rs1_idx  <= i_rs1_idx;
            rs1_data <= i_rs1_data;
            addr     <= i_csr_addr;
            rd       <= i_rd_addr;
         end
         if (state == S_READ) begin
            old_val  <= i_csr_rdata;
            new_val  <= alu_new;
            write_en <= alu_we;
         end
      end
   end

   csr_op_alu #(.XLEN(XLEN)) u_alu (
      .funct3   (funct3),
      .old_val  (i_csr_rdata),
      .rs1_data (rs1_data),
      .rs1_idx  (rs1_idx),
      .new_val  (alu_new),
      .write_en (alu_we)
   );

`ifdef CSR_ACCESS_CHECK_EN
   // top two address bits 2'b11 mark the read-only CSR space
   assign illegal = (state == S_WRITE) &&
                    (!is_csr_op(funct3) || (write_en && (addr[CSR_AW-1 -: 2] == 2'b11)));
`else
   assign illegal = 1'b0;
`endif

   assign o_illegal = illegal;

   always_comb begin
      state_nxt   = state;
      o_ready     = 1'b0;
      o_csr_addr  = '0;
      o_csr_we    = 1'b0;
      o_csr_wdata = '0;
      o_wb_valid  = 1'b0;
      o_wb_rd     = '0;
      o_wb_data   = '0;
      case (state)
         S_IDLE: begin
            o_ready = 1'b1;
            if (i_valid) state_nxt = S_READ;
         end
         S_READ: begin
            o_csr_addr = addr;
            state_nxt  = S_WRITE;
         end
         S_WRITE: begin
            o_csr_addr  = addr;
            o_csr_we    = write_en && !illegal;
            o_csr_wdata = new_val;
            o_wb_valid  = is_csr_op(funct3) && (rd != 5'd0) && !illegal;
            o_wb_rd     = rd;
            o_wb_data   = old_val;
            state_nxt   = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_csr_access_unit.sv
// Self-checking bench for csr_access_unit: directed vector table, hand-written
// multi-cycle sequences, and random ops against a transaction-level model.
module tb_csr_access_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        valid = 1'b0;
   logic        ready;
   logic [2:0]  funct3 = '0;
   logic [4:0]  rs1_idx = '0;
   logic [31:0] rs1_data = '0;
   logic [11:0] csr_addr_in = '0;
   logic [4:0]  rd_addr = '0;
   logic [11:0] csr_addr;
   logic [31:0] csr_rdata;
   logic        csr_we;
   logic [31:0] csr_wdata;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        illegal;

   logic [31:0] csr_mem [0:4095];
   logic [31:0] ref_csr [0:4095];
   logic        pre_we = 1'b0;
   logic [11:0] pre_addr = '0;
   logic [31:0] pre_data = '0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   csr_access_unit dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_valid     (valid),
      .o_ready     (ready),
      .i_funct3    (funct3),
      .i_rs1_idx   (rs1_idx),
      .i_rs1_data  (rs1_data),
      .i_csr_addr  (csr_addr_in),
      .i_rd_addr   (rd_addr),
      .o_csr_addr  (csr_addr),
      .i_csr_rdata (csr_rdata),
      .o_csr_we    (csr_we),
      .o_csr_wdata (csr_wdata),
      .o_wb_valid  (wb_valid),
      .o_wb_rd     (wb_rd),
      .o_wb_data   (wb_data),
      .o_illegal   (illegal)
   );

   // CSR file: combinational read, write committed on the clock edge
   assign csr_rdata = csr_mem[csr_addr];
   always @(posedge clk) begin
      if (pre_we)      csr_mem[pre_addr] <= pre_data;
      else if (csr_we) csr_mem[csr_addr] <= csr_wdata;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [11:0] a, input logic [31:0] d);
      @(negedge clk);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      @(posedge clk);
      #1 pre_we = 1'b0;
      ref_csr[a] = d;
   endtask

   // Architectural effect of one Zicsr op, derived from the instruction rules
   function automatic void model(input logic [2:0] f3, input logic [4:0] zimm,
                                 input logic [31:0] rs1v, input logic [11:0] a,
                                 input logic [4:0] rd, input logic [31:0] old,
                                 output logic we, output logic [31:0] wd,
                                 output logic wbv, output logic ill);
      logic [31:0] src;
      src = f3[2] ? {27'b0, zimm} : rs1v;
      we = 1'b0; wd = 32'h0; ill = 1'b0;
      case (f3[1:0])
         2'b01: begin we = 1'b1;          wd = src;        end
         2'b10: begin we = (zimm != 0);   wd = old | src;  end
         2'b11: begin we = (zimm != 0);   wd = old & ~src; end
         default: ;
      endcase
`ifdef CSR_ACCESS_CHECK_EN
      ill = (f3[1:0] == 2'b00) || (we && a[11:10] == 2'b11);
      if (ill) we = 1'b0;
`endif
      wbv = (f3[1:0] != 2'b00) && (rd != 0) && !ill;
   endfunction

   task automatic run_op(input string nm, input logic [2:0] f3, input logic [4:0] ri,
                         input logic [31:0] rv, input logic [11:0] a, input logic [4:0] rd,
                         input logic e_we, input logic [31:0] e_wd, input logic e_wbv,
                         input logic [31:0] e_wbd, input logic e_ill);
      int n = 0;
      @(negedge clk);
      while (!ready && n < 10) begin @(negedge clk); n++; end
      chk({nm, " ready"}, 32'(ready), 32'd1);
      funct3 = f3; rs1_idx = ri; rs1_data = rv; csr_addr_in = a; rd_addr = rd;
      valid = 1'b1;
      @(posedge clk);
      #1 valid = 1'b0;
      @(negedge clk);
      chk({nm, " read_ready"}, 32'(ready), 32'd0);
      chk({nm, " read_addr"}, 32'(csr_addr), 32'(a));
      @(negedge clk);
      chk({nm, " we"}, 32'(csr_we), 32'(e_we));
      if (e_we) chk({nm, " wdata"}, csr_wdata, e_wd);
      chk({nm, " wb_valid"}, 32'(wb_valid), 32'(e_wbv));
      if (e_wbv) begin
         chk({nm, " wb_rd"}, 32'(wb_rd), 32'(rd));
         chk({nm, " wb_data"}, wb_data, e_wbd);
      end
      chk({nm, " illegal"}, 32'(illegal), 32'(e_ill));
      if (e_we) ref_csr[a] = e_wd;
   endtask

   typedef struct {
      logic [2:0]  f3;
      logic [4:0]  ri;
      logic [31:0] rv;
      logic [11:0] a;
      logic [4:0]  rd;
      logic        pre;
      logic [31:0] pre_val;
      logic        we;
      logic [31:0] wd;
      logic        wbv;
      logic [31:0] wbd;
      logic        ill;
   } vec_t;

   vec_t tbl [10];

   initial begin
      logic        m_we, m_wbv, m_ill;
      logic [31:0] m_wd;
      logic [2:0]  rf3;
      logic [4:0]  rri, rrd;
      logic [31:0] rrv;
      logic [11:0] ra;
      logic [11:0] raddrs [5];

      //          f3      ri     rv            a       rd  pre  pre_val       we  wd            wbv wbd          ill
      tbl[0] = '{3'b001, 5'd7,  32'hDEADBEEF, 12'h300, 5'd5, 1, 32'h00000011, 1, 32'hDEADBEEF, 1, 32'h00000011, 0};
      tbl[1] = '{3'b010, 5'd0,  32'hFFFFFFFF, 12'h340, 5'd3, 1, 32'h000000A5, 0, 32'h0,        1, 32'h000000A5, 0};
      tbl[2] = '{3'b111, 5'h05, 32'h0,        12'h340, 5'd4, 0, 32'h0,        1, 32'h000000A0, 1, 32'h000000A5, 0};
      tbl[3] = '{3'b101, 5'h1F, 32'h0,        12'h341, 5'd0, 1, 32'h00000000, 1, 32'h0000001F, 0, 32'h0,        0};
      tbl[6] = '{3'b110, 5'h0A, 32'h0,        12'h305, 5'd8, 1, 32'h00000100, 1, 32'h0000010A, 1, 32'h00000100, 0};
      tbl[7] = '{3'b010, 5'd3,  32'h000000F0, 12'h305, 5'd9, 0, 32'h0,        1, 32'h000001FA, 1, 32'h0000010A, 0};
      tbl[8] = '{3'b011, 5'd2,  32'h000000FF, 12'h305, 5'd1, 0, 32'h0,        1, 32'h00000100, 1, 32'h000001FA, 0};
`ifdef CSR_ACCESS_CHECK_EN
      tbl[4] = '{3'b000, 5'd1,  32'h1,        12'h300, 5'd6, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1};
      tbl[5] = '{3'b001, 5'd4,  32'h00000055, 12'hC00, 5'd7, 1, 32'h00000099, 0, 32'h0,        0, 32'h0,        1};
      tbl[9] = '{3'b100, 5'd2,  32'h2,        12'h305, 5'd9, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1};
`else
      tbl[4] = '{3'b000, 5'd1,  32'h1,        12'h300, 5'd6, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0};
      tbl[5] = '{3'b001, 5'd4,  32'h00000055, 12'hC00, 5'd7, 1, 32'h00000099, 1, 32'h00000055, 1, 32'h00000099, 0};
      tbl[9] = '{3'b100, 5'd2,  32'h2,        12'h305, 5'd9, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0};
`endif

      #2 rst_n = 1'b0;
      #10;
      chk("rst ready", 32'(ready), 32'd1);
      chk("rst csr_addr", 32'(csr_addr), 32'd0);
      chk("rst we", 32'(csr_we), 32'd0);
      chk("rst wb_valid", 32'(wb_valid), 32'd0);
      chk("rst wb_data", wb_data, 32'd0);
      chk("rst illegal", 32'(illegal), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         if (tbl[i].pre) preload(tbl[i].a, tbl[i].pre_val);
         run_op($sformatf("vec%0d", i), tbl[i].f3, tbl[i].ri, tbl[i].rv, tbl[i].a, tbl[i].rd,
                tbl[i].we, tbl[i].wd, tbl[i].wbv, tbl[i].wbd, tbl[i].ill);
      end

      // back-to-back: i_valid held high, second op must wait until N+3
      preload(12'h7C0, 32'h00000022);
      @(negedge clk);
      funct3 = 3'b001; rs1_idx = 5'd9; rs1_data = 32'h12345678; csr_addr_in = 12'h7C0; rd_addr = 5'd1;
      valid = 1'b1;
      @(posedge clk);
      #1 funct3 = 3'b010; rs1_idx = 5'd0; rd_addr = 5'd2;
      @(negedge clk);
      chk("b2b ready n+1", 32'(ready), 32'd0);
      @(negedge clk);
      chk("b2b ready n+2", 32'(ready), 32'd0);
      chk("b2b we", 32'(csr_we), 32'd1);
      chk("b2b wdata", csr_wdata, 32'h12345678);
      chk("b2b wb_rd", 32'(wb_rd), 32'd1);
      chk("b2b wb_data", wb_data, 32'h00000022);
      @(negedge clk);
      chk("b2b ready n+3", 32'(ready), 32'd1);
      chk("b2b we n+3", 32'(csr_we), 32'd0);
      @(posedge clk);
      #1 valid = 1'b0;
      @(negedge clk);
      chk("b2b2 addr", 32'(csr_addr), 32'h7C0);
      @(negedge clk);
      chk("b2b2 we", 32'(csr_we), 32'd0);
      chk("b2b2 wb_valid", 32'(wb_valid), 32'd1);
      chk("b2b2 wb_rd", 32'(wb_rd), 32'd2);
      chk("b2b2 wb_data", wb_data, 32'h12345678);
      ref_csr[12'h7C0] = 32'h12345678;

      // reset during READ aborts the op with no write
      @(negedge clk);
      funct3 = 3'b001; rs1_idx = 5'd1; rs1_data = 32'hBAD0BAD0; csr_addr_in = 12'h300; rd_addr = 5'd3;
      valid = 1'b1;
      @(posedge clk);
      #1 valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid rst ready", 32'(ready), 32'd1);
      chk("mid rst csr_addr", 32'(csr_addr), 32'd0);
      chk("mid rst we", 32'(csr_we), 32'd0);
      chk("mid rst wb_valid", 32'(wb_valid), 32'd0);
      #2 rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("post rst we", 32'(csr_we), 32'd0);
         chk("post rst ready", 32'(ready), 32'd1);
      end
      chk("post rst csr kept", csr_mem[12'h300], ref_csr[12'h300]);

      // random ops against the transaction model
      raddrs = '{12'h300, 12'h305, 12'h340, 12'hC01, 12'h7C1};
      foreach (raddrs[j]) preload(raddrs[j], $urandom);
      for (int t = 0; t < 150; t++) begin
         rf3 = 3'($urandom_range(0, 7));
         rri = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         rrd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         rrv = $urandom;
         ra  = raddrs[$urandom_range(0, 4)];
         model(rf3, rri, rrv, ra, rrd, ref_csr[ra], m_we, m_wd, m_wbv, m_ill);
         run_op($sformatf("rnd%0d", t), rf3, rri, rrv, ra, rrd, m_we, m_wd, m_wbv, ref_csr[ra], m_ill);
      end
      @(negedge clk);
      @(negedge clk);
      foreach (raddrs[j]) chk("rnd final csr", csr_mem[raddrs[j]], ref_csr[raddrs[j]]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
